// File: rtl/fifo_tx_pkg.sv
// fifo_tx_pkg: shared state encoding and constants for the FIFO-fed UART transmitter
package fifo_tx_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} tx_state_t;
  localparam int DATA_W = 8;
  localparam logic TX_IDLE_LVL = 1'b1;
endpackage

// File: rtl/fifo_uart_tx_baud_counter.sv
// tx_baud_counter: bit-period timer that ticks on the last clock of every serial bit
module tx_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] r_count;
  // count one bit period, wrapping on each boundary and parking at zero while cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_count <= '0;
    else r_count <= (clear || bit_tick) ? '0 : r_count + 1'b1;
  end
  assign bit_tick = r_count == LAST;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and serialises them as UART frames
module fifo_uart_tx
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic              fifo_wr_active,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);
  localparam int SW = $clog2(2 * CLKS_PER_BIT);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_PRE = SW'(STOP_BITS * CLKS_PER_BIT - 2);
  tx_state_t r_state;
  logic [DATA_W-1:0] r_shift;
  logic [2:0] r_bit_idx;
  logic [SW-1:0] r_stop_cnt;
  logic r_tx;
  logic r_frame_done;
  logic w_tick;
  logic w_clear;
  logic w_read_ok;
  logic w_next_frame;
  assign w_clear = r_state inside {IDLE, FETCH, LOAD};
  assign w_read_ok = !fifo_empty && !fifo_wr_active;
  assign w_next_frame = enable && !fifo_empty;
  assign fifo_read = r_state == FETCH;
  assign busy = r_state != IDLE;
  assign tx = r_tx;
  assign frame_done = r_frame_done;
  tx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(w_clear),
    .bit_tick(w_tick)
  );
  // frame sequencer: pop, load, start bit, eight data bits LSB first, stop period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit_idx <= '0;
      r_stop_cnt <= '0;
      r_tx <= TX_IDLE_LVL;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: if (w_next_frame) r_state <= FETCH;
        FETCH: r_state <= w_read_ok ? LOAD : IDLE;
        LOAD: begin
          r_shift <= fifo_data;
          r_tx <= 1'b0;
          r_state <= START;
        end
        START: if (w_tick) begin
          r_tx <= r_shift[0];
          r_bit_idx <= '0;
          r_state <= DATA;
        end
        DATA: if (w_tick) begin
          r_shift <= r_shift >> 1;
          r_bit_idx <= r_bit_idx + 3'd1;
          r_tx <= (r_bit_idx == 3'd7) ? TX_IDLE_LVL : r_shift[1];
          if (r_bit_idx == 3'd7) begin
            r_stop_cnt <= '0;
            r_state <= STOP;
          end
        end
        STOP: begin
          r_stop_cnt <= r_stop_cnt + 1'b1;
          r_frame_done <= r_stop_cnt == STOP_PRE;
          if (w_tick && r_stop_cnt == STOP_LAST) r_state <= w_next_frame ? FETCH : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
